// File: rtl/mem_router_pkg.sv
// Shared types, default memory map and address decoder for mem_router.
package mem_router_pkg;

  localparam int MAX_DEV = 8;

  localparam logic [31:0] GPIO_BASE    = 32'h0000_0100;
  localparam logic [31:0] GPIO_MASK    = 32'hFFFF_FFF0;
  localparam logic [31:0] TIMER_BASE   = 32'h0000_010B;
  localparam logic [31:0] TIMER_MASK   = 32'hFFFF_FFFF;
  localparam logic [31:0] STORAGE_BASE = 32'h0000_1000;
  localparam logic [31:0] STORAGE_MASK = 32'hFFFF_F000;
  localparam logic [31:0] EXT_SPI_BASE = 32'h8000_0000;
  localparam logic [31:0] EXT_SPI_MASK = 32'h8000_0000;

  typedef struct packed {
    logic       unmapped;
    logic [2:0] sel;
  } tag_t;

  // Scan downwards so the lowest-index matching region is the one left standing.
  function automatic tag_t decode(input logic [31:0]                  addr,
                                  input logic [MAX_DEV-1:0][31:0]     base,
                                  input logic [MAX_DEV-1:0][31:0]     mask,
                                  input logic [MAX_DEV-1:0]           en);
    tag_t t;
    t.unmapped = 1'b1;
    t.sel      = 3'd0;
    for (int i = MAX_DEV - 1; i >= 0; i--) begin
      if (en[i] && ((addr & mask[i]) == base[i])) begin
        t.unmapped = 1'b0;
        t.sel      = 3'(i);
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/mem_router_fifo.sv
// Synchronous tag FIFO tracking outstanding requests in issue order.
module mem_router_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_cnt;
  logic             w_push, w_pop;

  assign full_o  = (r_cnt == (AW+1)'(DEPTH));
  assign empty_o = (r_cnt == '0);
  assign head_o  = r_mem[r_rp];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/mem_router.sv
// Region-table memory router with in-order response tracking.
// Optional response timeout with sticky dead-target marking: MEM_ROUTER_TIMEOUT_EN.
module mem_router
  import mem_router_pkg::*;
#(
  parameter int                       MEM_W       = 32,
  parameter int                       N_DEV       = 4,
  parameter int                       MAX_OUTST   = 4,
  parameter logic [N_DEV-1:0][31:0]   DEV_BASE    = {EXT_SPI_BASE, STORAGE_BASE, TIMER_BASE, GPIO_BASE},
  parameter logic [N_DEV-1:0][31:0]   DEV_MASK    = {EXT_SPI_MASK, STORAGE_MASK, TIMER_MASK, GPIO_MASK},
  parameter int                       TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   host_req_i,
  output logic                   host_gnt_o,
  input  logic [31:0]            host_addr_i,
  input  logic                   host_we_i,
  input  logic [MEM_W/8-1:0]     host_be_i,
  input  logic [MEM_W-1:0]       host_wdata_i,
  output logic                   host_rvalid_o,
  output logic                   host_err_o,
  output logic [MEM_W-1:0]       host_rdata_o,
  output logic [N_DEV-1:0]       dev_req_o,
  input  logic [N_DEV-1:0]       dev_gnt_i,
  output logic [31:0]            dev_addr_o,
  output logic                   dev_we_o,
  output logic [MEM_W/8-1:0]     dev_be_o,
  output logic [MEM_W-1:0]       dev_wdata_o,
  input  logic [N_DEV-1:0]       dev_rvalid_i,
  input  logic [N_DEV-1:0]       dev_err_i,
  input  logic [N_DEV*MEM_W-1:0] dev_rdata_i
);

  if ((MEM_W % 8) != 0 || N_DEV < 1 || N_DEV > MAX_DEV || MAX_OUTST < 2 ||
      (MAX_OUTST & (MAX_OUTST - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("mem_router: illegal parameter set");
  end

  logic [MAX_DEV-1:0][31:0] w_base, w_mask;
  logic [MAX_DEV-1:0]       w_en, w_dead;
  tag_t                     w_req_tag, w_head;
  logic                     w_full, w_empty, w_push, w_pop;
  logic                     w_sel_gnt, w_hd_rv_raw, w_hd_rv, w_hd_err, w_tmo;
  logic                     w_err_rsp, w_dev_rsp;
  logic [MEM_W-1:0]         w_hd_rdata;

  always_comb begin
    w_base = '0;
    w_mask = '0;
    w_en   = '0;
    for (int i = 0; i < N_DEV; i++) begin
      w_base[i] = DEV_BASE[i];
      w_mask[i] = DEV_MASK[i];
      w_en[i]   = ~w_dead[i];
    end
  end

  assign w_req_tag = decode(host_addr_i, w_base, w_mask, w_en);

  always_comb begin
    w_sel_gnt   = 1'b0;
    w_hd_rv_raw = 1'b0;
    w_hd_err    = 1'b0;
    w_hd_rdata  = '0;
    dev_req_o   = '0;
    for (int i = 0; i < N_DEV; i++) begin
      if (w_req_tag.sel == 3'(i)) w_sel_gnt = dev_gnt_i[i];
      if (w_head.sel == 3'(i)) begin
        w_hd_rv_raw = dev_rvalid_i[i];
        w_hd_err    = dev_err_i[i];
        w_hd_rdata  = dev_rdata_i[i*MEM_W +: MEM_W];
      end
      dev_req_o[i] = host_req_i & ~w_full & ~w_req_tag.unmapped & (w_req_tag.sel == 3'(i));
    end
  end

  // full comes from the registered count only, keeping rvalid out of the gnt path.
  assign host_gnt_o = host_req_i & ~w_full & (w_req_tag.unmapped | w_sel_gnt);
  assign w_push     = host_gnt_o;

  assign dev_addr_o  = host_addr_i;
  assign dev_we_o    = host_we_i;
  assign dev_be_o    = host_be_i;
  assign dev_wdata_o = host_wdata_i;

  assign w_hd_rv   = w_hd_rv_raw & ~w_dead[w_head.sel];
  assign w_err_rsp = ~w_empty & (w_head.unmapped | w_tmo);
  assign w_dev_rsp = ~w_empty & ~w_head.unmapped & w_hd_rv;

  assign host_rvalid_o = w_err_rsp | w_dev_rsp;
  assign host_err_o    = w_err_rsp | (w_dev_rsp & w_hd_err);
  assign host_rdata_o  = w_dev_rsp ? w_hd_rdata : '0;
  assign w_pop         = host_rvalid_o;

  mem_router_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH ($bits(tag_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .wdata_i (w_req_tag),
    .full_o  (w_full),
    .empty_o (w_empty),
    .head_o  (w_head)
  );

`ifdef MEM_ROUTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0]    r_tmo_cnt;
  logic [N_DEV-1:0] r_dead;

  assign w_dead = MAX_DEV'(r_dead);
  // A real response in the same cycle as expiry wins over the timeout.
  assign w_tmo  = ~w_empty & ~w_head.unmapped & ~w_hd_rv & (r_tmo_cnt == TW'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt <= '0;
      r_dead    <= '0;
    end else begin
      if (w_pop)                              r_tmo_cnt <= '0;
      else if (~w_empty & ~w_head.unmapped)   r_tmo_cnt <= r_tmo_cnt + TW'(1);
      if (w_tmo) begin
        for (int i = 0; i < N_DEV; i++)
          if (w_head.sel == 3'(i)) r_dead[i] <= 1'b1;
      end
    end
  end
`else
  assign w_dead = '0;
  assign w_tmo  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_router.sv
// Randomised and directed bench for mem_router against a queue-based reference model.
module tb_mem_router;

  localparam int TMO = 8;
`ifdef MEM_ROUTER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam logic [31:0] BASE [4] = '{32'h0000_0100, 32'h0000_010B, 32'h0000_1000, 32'h8000_0000};
  localparam logic [31:0] MASK [4] = '{32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'hFFFF_F000, 32'h8000_0000};

  logic         clk, rst;
  logic         req, gnt, we, rv, err;
  logic [31:0]  addr, wdata, rdata;
  logic [3:0]   be;
  logic [3:0]   dreq, dgnt, drv, derr;
  logic [31:0]  daddr, dwdata;
  logic         dwe;
  logic [3:0]   dbe;
  logic [127:0] drdata;

  mem_router #(
    .MEM_W(32), .N_DEV(4), .MAX_OUTST(4), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .host_req_i(req), .host_gnt_o(gnt), .host_addr_i(addr), .host_we_i(we),
    .host_be_i(be), .host_wdata_i(wdata),
    .host_rvalid_o(rv), .host_err_o(err), .host_rdata_o(rdata),
    .dev_req_o(dreq), .dev_gnt_i(dgnt), .dev_addr_o(daddr), .dev_we_o(dwe),
    .dev_be_o(dbe), .dev_wdata_o(dwdata),
    .dev_rvalid_i(drv), .dev_err_i(derr), .dev_rdata_i(drdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { bit unm; int tgt; } ent_t;
  ent_t q[$];
  int   pend [4];
  bit   dead [4];
  int   hw;
  int   n_vec = 0, n_err = 0;

  logic        s_gnt, s_rv, s_err;
  logic [3:0]  s_req;
  logic [31:0] s_rdata;

  function automatic int mdecode(logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if (!dead[i] && ((a & MASK[i]) == BASE[i])) return i;
    return -1;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: dut=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    req = 0; addr = 0; we = 0; be = 0; wdata = 0;
    dgnt = 4'hF; drv = 0; derr = 0; drdata = '0;
  endtask

  // One clock: predict outputs from current inputs and model state, compare, then advance the model.
  task automatic step();
    ent_t        h;
    int          t;
    bit          full, e_gnt, e_rv, e_err, tmo;
    logic [3:0]  e_req;
    logic [31:0] e_rdata;
    @(negedge clk);
    t     = mdecode(addr);
    full  = (q.size() >= 4);
    e_req = '0;
    if (req && !full && t >= 0) e_req[t] = 1'b1;
    e_gnt = req && !full && (t < 0 || dgnt[t]);
    e_rv = 0; e_err = 0; e_rdata = '0; tmo = 0;
    h = '{unm: 1'b0, tgt: 0};
    if (q.size() > 0) begin
      h = q[0];
      if (h.unm) begin
        e_rv = 1; e_err = 1;
      end else if (drv[h.tgt] && !dead[h.tgt]) begin
        e_rv = 1; e_err = derr[h.tgt]; e_rdata = drdata[h.tgt*32 +: 32];
      end else if (TMO_EN && hw == TMO) begin
        e_rv = 1; e_err = 1; tmo = 1;
      end
    end
    s_gnt = gnt; s_req = dreq; s_rv = rv; s_err = err; s_rdata = rdata;
    n_vec++;
    chk("gnt",     {31'd0, gnt},  {31'd0, e_gnt});
    chk("dev_req", {28'd0, dreq}, {28'd0, e_req});
    chk("rvalid",  {31'd0, rv},   {31'd0, e_rv});
    chk("err",     {31'd0, err},  {31'd0, e_err});
    chk("rdata",   rdata,         e_rdata);
    chk("bcast",   daddr ^ dwdata ^ {27'd0, dwe, dbe}, addr ^ wdata ^ {27'd0, we, be});
    @(posedge clk);
    if (rst) begin
      q.delete();
      hw = 0;
      for (int i = 0; i < 4; i++) begin pend[i] = 0; dead[i] = 0; end
    end else begin
      if (e_rv) begin
        if (!h.unm) pend[h.tgt]--;
        if (tmo) dead[h.tgt] = 1;
        void'(q.pop_front());
        hw = 0;
      end else if (q.size() > 0 && !q[0].unm) begin
        hw++;
      end
      if (e_gnt) begin
        q.push_back('{unm: (t < 0), tgt: t});
        if (t >= 0) pend[t]++;
      end
    end
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    hw = 0;
    for (int i = 0; i < 4; i++) begin pend[i] = 0; dead[i] = 0; end
    idle();
    rst = 1;
    step(); step();
    chk("rst_gnt",  {31'd0, s_gnt}, 32'd0);
    chk("rst_rv",   {31'd0, s_rv},  32'd0);
    chk("rst_data", s_rdata,        32'd0);
    rst = 0;

    // Unmapped read into an empty router.
    idle(); req = 1; addr = 32'h0000_0050;
    step();
    chk("unm_gnt", {31'd0, s_gnt}, 32'd1);
    chk("unm_req", {28'd0, s_req}, 32'd0);
    idle(); step();
    chk("unm_rv",  {31'd0, s_rv},  32'd1);
    chk("unm_err", {31'd0, s_err}, 32'd1);
    chk("unm_rd",  s_rdata,        32'd0);

    // In-order return: dev0 then dev2, dev2 answers early and is ignored.
    idle(); req = 1; addr = 32'h0000_0104; step();
    chk("ord_req0", {28'd0, s_req}, 32'h1);
    addr = 32'h0000_1004; step();
    chk("ord_req2", {28'd0, s_req}, 32'h4);
    idle(); drv = 4'b0100; drdata[64 +: 32] = 32'hBBBB_0002; step();
    chk("ord_early", {31'd0, s_rv}, 32'd0);
    idle(); drv = 4'b0001; drdata[0 +: 32] = 32'hAAAA_0000; step();
    chk("ord_rd0", s_rdata, 32'hAAAA_0000);
    idle(); drv = 4'b0100; drdata[64 +: 32] = 32'hBBBB_0002; step();
    chk("ord_rd2", s_rdata, 32'hBBBB_0002);
    idle(); step();

    // Fill four slots, then check the fifth request and release timing.
    for (int i = 0; i < 4; i++) begin
      idle(); req = 1; addr = 32'h0000_1000 + 32'(i * 4); step();
      chk("full_fill", {31'd0, s_gnt}, 32'd1);
    end
    step();
    chk("full_gnt", {31'd0, s_gnt}, 32'd0);
    chk("full_req", {28'd0, s_req}, 32'd0);
    drv = 4'b0100; drdata[64 +: 32] = 32'hC0C0_0001; step();
    chk("full_pop_gnt", {31'd0, s_gnt}, 32'd0);
    chk("full_pop_rd",  s_rdata,        32'hC0C0_0001);
    drv = 4'b0000; step();
    chk("full_free_gnt", {31'd0, s_gnt}, 32'd1);
    idle();
    for (int i = 0; i < 12 && q.size() > 0; i++) begin
      drv = 4'b0100; step();
    end
    idle(); step();

    // Target back-pressure; 0x10B lies in both dev0 and dev1 regions, dev0 wins.
    idle(); req = 1; addr = 32'h0000_010B; we = 1; be = 4'hF; wdata = 32'h1234_5678;
    dgnt = 4'b1100; drv = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_gnt", {31'd0, s_gnt}, 32'd0);
      chk("bp_req", {28'd0, s_req}, 32'h1);
      chk("bp_rv",  {31'd0, s_rv},  32'd0);
    end
    drv = 4'b0000; dgnt = 4'hF; step();
    chk("bp_gnt4", {31'd0, s_gnt}, 32'd1);
    idle(); drv = 4'b0001; step();
    chk("bp_ack", {31'd0, s_rv}, 32'd1);

    // Reset with two requests in flight.
    idle(); req = 1; addr = 32'h0000_0104; step();
    addr = 32'h0000_1008; step();
    idle(); rst = 1; step();
    rst = 0; drv = 4'b1111; step();
    chk("rstm_rv",  {31'd0, s_rv},  32'd0);
    chk("rstm_req", {28'd0, s_req}, 32'd0);
    chk("rstm_rd",  s_rdata,        32'd0);
    idle(); step();

`ifdef MEM_ROUTER_TIMEOUT_EN
    // Silent dev3 times out, then decodes as unmapped.
    idle(); req = 1; addr = 32'h8000_0000; step();
    chk("tmo_req", {28'd0, s_req}, 32'h8);
    idle();
    for (int i = 0; i < TMO; i++) begin
      step();
      chk("tmo_wait", {31'd0, s_rv}, 32'd0);
    end
    step();
    chk("tmo_rv",  {31'd0, s_rv},  32'd1);
    chk("tmo_err", {31'd0, s_err}, 32'd1);
    req = 1; addr = 32'h8000_0000; step();
    chk("dead_req", {28'd0, s_req}, 32'd0);
    chk("dead_gnt", {31'd0, s_gnt}, 32'd1);
    idle(); step();
    chk("dead_err", {31'd0, s_err}, 32'd1);
    rst = 1; step(); rst = 0;
`endif

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      req = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 5))
        0:       addr = 32'h0000_0050;
        1:       addr = 32'h0000_0100 | ($urandom & 32'hF);
        2:       addr = 32'h0000_010B;
        3:       addr = 32'h0000_1000 | ($urandom & 32'hFFF);
        4:       addr = 32'h8000_0000 | $urandom;
        default: addr = $urandom;
      endcase
      we = $urandom_range(0, 1); be = 4'($urandom); wdata = $urandom;
      for (int t = 0; t < 4; t++) begin
        dgnt[t] = ($urandom_range(0, 3) != 0);
        drv[t]  = (pend[t] > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
        derr[t] = ($urandom_range(0, 4) == 0);
        drdata[t*32 +: 32] = $urandom;
      end
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 0; idle();
    for (int i = 0; i < 40; i++) begin
      drv = 4'hF; step();
    end
    idle(); step();
    chk("drain_rv", {31'd0, s_rv}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
